// File: rtl/sm3_pkg.sv
// Shared SM3 constants, compression FSM encoding and the boolean/permutation helpers.
package sm3_pkg;

  localparam logic [255:0] SM3_IV = 256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;
  localparam logic [31:0]  T_LOW  = 32'h79CC4519;
  localparam logic [31:0]  T_HIGH = 32'h7A879D8A;
  localparam logic [5:0]   LAST_ROUND = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } sm3_state_e;

  // Only ever called with constant amounts, so each use collapses to wiring.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    rotl32 = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic hi);
    ff_j = hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic hi);
    gg_j = hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    p0 = x ^ rotl32(x, 9) ^ rotl32(x, 17);
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit variable rotate-left, five log stages; purely combinational, no flow control.
module barrel_shifter (
  input  logic [31:0] data_in,
  input  logic [4:0]  shift,
  output logic [31:0] data_out
);

  logic [31:0] s0, s1, s2, s3;

  assign s0       = shift[0] ? {data_in[30:0], data_in[31]}  : data_in;
  assign s1       = shift[1] ? {s0[29:0], s0[31:30]}         : s0;
  assign s2       = shift[2] ? {s1[27:0], s1[31:28]}         : s1;
  assign s3       = shift[3] ? {s2[23:0], s2[31:24]}         : s2;
  assign data_out = shift[4] ? {s3[15:0], s3[31:16]}         : s3;

endmodule

// File: rtl/sm3_compress_core.sv
// SM3 CF(V_i, B_i): 66 cycles start->done unstalled, one round per W handshake, low w_valid_in holds.
// Defining SM3_COMPRESS_ABORT_EN adds abort_in, which drops a block in ROUND/FINAL back to IDLE.
module sm3_compress_core
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_in,
  input  logic [255:0] v_in,
  input  logic         w_valid_in,
  input  logic [31:0]  w_in,
  input  logic [31:0]  wp_in,
`ifdef SM3_COMPRESS_ABORT_EN
  input  logic         abort_in,
`endif
  output logic         w_ready_out,
  output logic         busy_out,
  output logic         done_out,
  output logic [255:0] v_out,
  output logic [5:0]   round_out
);

  sm3_state_e   state_q, state_d;
  logic [255:0] work_q, work_d;
  logic [255:0] vsave_q, vsave_d;
  logic [255:0] vres_q, vres_d;
  logic [5:0]   j_q, j_d;

  logic         abort, fire, hi_round;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  t_j, t_rot, a12, ss1, ss2, tt1, tt2;
  logic [255:0] v_final;

`ifdef SM3_COMPRESS_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  assign {a, b, c, d, e, f, g, h} = work_q;
  assign fire     = w_valid_in && w_ready_out;
  assign hi_round = (j_q >= 6'd16);
  assign t_j      = hi_round ? T_HIGH : T_LOW;

  barrel_shifter u_shift (
    .data_in  (t_j),
    .shift    (j_q[4:0]),
    .data_out (t_rot)
  );

  assign a12     = rotl32(a, 12);
  assign ss1     = rotl32(a12 + e + t_rot, 7);
  assign ss2     = ss1 ^ a12;
  assign tt1     = ff_j(a, b, c, hi_round) + d + ss2 + wp_in;
  assign tt2     = gg_j(e, f, g, hi_round) + h + ss1 + w_in;
  assign v_final = work_q ^ vsave_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = ROUND;
      ROUND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (fire && (j_q == LAST_ROUND)) begin
          state_d = FINAL;
        end
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_out and the fresh digest are presented during FINAL itself; vres_q holds it afterwards.
  always_comb begin
    w_ready_out = (state_q == ROUND);
    busy_out    = (state_q != IDLE);
    done_out    = (state_q == FINAL) && !abort;
    round_out   = (state_q == IDLE) ? 6'd0 : j_q;
    v_out       = done_out ? v_final : vres_q;
  end

  always_comb begin
    work_d  = work_q;
    vsave_d = vsave_q;
    vres_d  = vres_q;
    j_d     = j_q;
    if ((state_q == IDLE) && start_in) begin
      work_d  = v_in;
      vsave_d = v_in;
      j_d     = 6'd0;
    end
    if ((state_q == ROUND) && fire && !abort) begin
      work_d = {tt1, a, rotl32(b, 9), c, p0(tt2), e, rotl32(f, 19), g};
      if (j_q != LAST_ROUND) j_d = j_q + 6'd1;
    end
    if (done_out) vres_d = v_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      vsave_q <= '0;
      vres_q  <= '0;
      j_q     <= '0;
    end else begin
      work_q  <= work_d;
      vsave_q <= vsave_d;
      vres_q  <= vres_d;
      j_q     <= j_d;
    end
  end

endmodule

// File: tb/tb_sm3_compress_core.sv
// Self-checking bench for sm3_compress_core: table of block vectors plus reset/start/abort sequences.
module tb_sm3_compress_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_in;
  logic [255:0] v_in;
  logic         w_valid_in;
  logic [31:0]  w_in, wp_in;
  logic         abort_in;
  logic         w_ready_out, busy_out, done_out;
  logic [255:0] v_out;
  logic [5:0]   round_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] IV          = 256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;
  localparam logic [255:0] ABC_DIGEST  = 256'h66C7F0F4_62EEEDD9_D1F2D46B_DC10E4E2_4167C487_5CF2F7A2_297DA02B_8F4BA8E0;
  localparam logic [255:0] ABCD_DIGEST = 256'hDEBE9FF9_2275B8A1_38604889_C18E5A4D_6FDB70E5_387E5765_293DCBA3_9C0C5732;
  localparam logic [511:0] ABC_BLK     = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ABCD_BLK    = {16{32'h61626364}};
  localparam logic [511:0] PAD_BLK     = {32'h80000000, 448'h0, 32'h00000200};

  typedef struct {
    logic [255:0] v;
    logic [511:0] blk;
    logic [255:0] exp;
    bit           stall;
    int           start_at;
    int           exp_cyc;
    bit           chk_shift;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] wexp [68];

  sm3_compress_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .v_in        (v_in),
    .w_valid_in  (w_valid_in),
    .w_in        (w_in),
    .wp_in       (wp_in),
`ifdef SM3_COMPRESS_ABORT_EN
    .abort_in    (abort_in),
`endif
    .w_ready_out (w_ready_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .v_out       (v_out),
    .round_out   (round_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: textbook SM3 expansion and compression on plain arrays.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int m = n % 32;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  function automatic logic [31:0] mp0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] mp1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  function automatic void expand(input logic [511:0] blk);
    for (int j = 0; j < 16; j++) wexp[j] = blk[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      wexp[j] = mp1(wexp[j-16] ^ wexp[j-9] ^ rl(wexp[j-3], 15)) ^ rl(wexp[j-13], 7) ^ wexp[j-6];
  endfunction

  function automatic logic [255:0] ref_cf(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] r [8];
    logic [31:0] t, ss1, ss2, fv, gv, tt1, tt2;
    expand(blk);
    for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79CC4519 : 32'h7A879D8A;
      ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
      ss2 = ss1 ^ rl(r[0], 12);
      fv  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      gv  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = fv + r[3] + ss2 + (wexp[j] ^ wexp[j+4]);
      tt2 = gv + r[7] + ss1 + wexp[j];
      r[3] = r[2]; r[2] = rl(r[1], 9);  r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = mp0(tt2);
    end
    return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] x = '0;
    for (int i = 0; i < 8; i++) x = {x[223:0], 32'($urandom())};
    return x;
  endfunction

  // Drives one block as the expansion stage would; optional start/reset/abort injection at round k.
  task automatic run_block(input logic [255:0] v, input logic [511:0] blk, input bit stall,
                           input int start_at, input int rst_at, input int abort_at,
                           input bit chk_shift, output logic [255:0] res, output int done_cyc);
    logic [31:0] w [68];
    logic [31:0] t_rot;
    int k, cyc, jerr, dones;
    bit fire, ended, aborted;
    expand(blk);
    for (int i = 0; i < 68; i++) w[i] = wexp[i];
    k = 0; cyc = 1; jerr = 0; ended = 0; aborted = 0; res = '0; done_cyc = 0;
    t_rot = (32'h7A879D8A << 1) | (32'h7A879D8A >> 31);
    @(negedge clk);
    start_in = 1'b1; v_in = v; w_valid_in = 1'b0;
    for (int t = 0; t < 600 && !ended; t++) begin
      @(negedge clk);
      cyc++;
      start_in = (k == start_at);
      v_in     = ~v;
      if (busy_out && (round_out != ((k > 63) ? 6'd63 : 6'(k)))) jerr++;
      if (done_out) begin
        res = v_out; done_cyc = cyc; ended = 1'b1;
        if (w_ready_out) jerr++;
      end else if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 256'({busy_out, done_out, w_ready_out, round_out}), '0);
        check("rst_mid_vout", v_out, '0);
        ended = 1'b1;
      end else begin
        if (chk_shift && busy_out && round_out == 6'd15)
          check("shift_in_j15", 256'(dut.u_shift.data_in), 256'h79CC4519);
        if (chk_shift && busy_out && round_out == 6'd16)
          check("shift_in_j16", 256'(dut.u_shift.data_in), 256'h7A879D8A);
        if (chk_shift && busy_out && round_out == 6'd33)
          check("shift_out_j33", 256'(dut.u_shift.data_out), 256'(t_rot));
        abort_in   = (k == abort_at);
        w_valid_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (k < 64) begin
          w_in  = w[k];
          wp_in = w[k] ^ w[k+4];
        end
        fire = w_valid_in && w_ready_out;
        @(posedge clk);
        if (abort_in) begin
          aborted = 1'b1; ended = 1'b1;
        end else if (fire) begin
          k++;
        end
      end
    end
    check("no_timeout", 256'(ended), 256'(1));
    @(negedge clk);
    start_in = 1'b0; abort_in = 1'b0; w_valid_in = 1'b0; rst_n = 1'b1;
    check("idle_after", 256'(busy_out), '0);
    check("jtrack", 256'(jerr), '0);
    if (aborted) begin
      dones = 0;
      repeat (80) begin
        @(negedge clk);
        if (done_out) dones++;
      end
      check("abort_no_done", 256'(dones), '0);
      res = v_out;
    end
  endtask

  initial begin
    logic [255:0] res, res1, exp1, prev;
    int dc;
    rst_n = 1'b0; start_in = 1'b0; v_in = '0; w_valid_in = 1'b0;
    w_in = '0; wp_in = '0; abort_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 256'({busy_out, done_out, w_ready_out, round_out}), '0);
    check("rst_vout", v_out, '0);
    rst_n = 1'b1;

    tbl[0] = '{v: IV, blk: ABC_BLK, exp: ABC_DIGEST, stall: 1'b0, start_at: -1, exp_cyc: 66, chk_shift: 1'b1};
    tbl[1] = '{v: IV, blk: ABC_BLK, exp: ABC_DIGEST, stall: 1'b1, start_at: -1, exp_cyc: 0, chk_shift: 1'b0};
    for (int i = 2; i < 5; i++) begin
      tbl[i].v = rnd256();
      tbl[i].blk = {rnd256(), rnd256()};
      tbl[i].exp = ref_cf(tbl[i].v, tbl[i].blk);
      tbl[i].stall = (i != 2);
      tbl[i].start_at = (i == 2) ? 64 : ((i == 3) ? 5 : -1);
      tbl[i].exp_cyc = (i == 2) ? 66 : 0;
      tbl[i].chk_shift = 1'b0;
    end

    for (int i = 0; i < 5; i++) begin
      run_block(tbl[i].v, tbl[i].blk, tbl[i].stall, tbl[i].start_at, -1, -1,
                tbl[i].chk_shift, res, dc);
      check($sformatf("vec%0d_digest", i), res, tbl[i].exp);
      if (tbl[i].exp_cyc != 0)
        check($sformatf("vec%0d_latency", i), 256'(dc), 256'(tbl[i].exp_cyc));
    end

    // Two-block chain with a stray start_in mid-block on the first.
    exp1 = ref_cf(IV, ABCD_BLK);
    run_block(IV, ABCD_BLK, 1'b0, 20, -1, -1, 1'b0, res1, dc);
    check("chain_blk1", res1, exp1);
    run_block(res1, PAD_BLK, 1'b1, -1, -1, -1, 1'b0, res, dc);
    check("chain_digest", res, ABCD_DIGEST);
    check("chain_hold", v_out, ABCD_DIGEST);

    run_block(IV, ABC_BLK, 1'b0, -1, 40, -1, 1'b0, res, dc);
    run_block(IV, ABC_BLK, 1'b0, -1, -1, -1, 1'b0, res, dc);
    check("after_rst_digest", res, ABC_DIGEST);

`ifdef SM3_COMPRESS_ABORT_EN
    prev = v_out;
    run_block(ABCD_DIGEST, PAD_BLK, 1'b0, -1, -1, 10, 1'b0, res, dc);
    check("abort_keeps_vout", res, prev);
    run_block(IV, ABC_BLK, 1'b1, -1, -1, -1, 1'b0, res, dc);
    check("after_abort_digest", res, ABC_DIGEST);
`else
    prev = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
